mem_stage: RTL

// - Memory-access stage directly downstream of the dual-issue execute stage.
// - Takes one two-slot bundle of execute results plus load/store requests.
// - Performs the bundle's loads/stores in order (slot0 then slot1) over a single data-memory port.
// - Produces a registered two-slot writeback bundle; stalls upstream via in_ready while busy.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: runs a dual-issue bundle's loads/stores in slot order over
// one data-memory port and emits a registered two-slot writeback bundle.
module mem_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_slot_vld,
    input  logic [1:0]          in_load,
    input  logic [1:0]          in_store,
    input  logic [1:0][1:0]     in_size,
    input  logic [1:0]          in_sext,
    input  logic [1:0][AW-1:0]  in_addr,
    input  logic [1:0][DW-1:0]  in_wdata,
    input  logic [1:0][DW-1:0]  in_result,
    input  logic [1:0][4:0]     in_wreg,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [AW-1:0]       dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [DW-1:0]       dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DW-1:0]       dmem_rdata,
    output logic [1:0]          wb_valid,
    output logic [1:0][4:0]     wb_reg,
    output logic [1:0][DW-1:0]  wb_data,
    output logic [1:0]          wb_exc
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t state, state_nx;

    logic [1:0]          vld_q, st_q, exc_q, go_q, sext_q;
    logic [1:0][1:0]     size_q;
    logic [1:0][AW-1:0]  addr_q;
    logic [1:0][DW-1:0]  wdata_q, data_q;
    logic [1:0][4:0]     wreg_q;

    logic [1:0]          mem_op, mis, exc_in, go_in;
    logic                sel;

    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] rd, input logic [1:0] a,
                                               input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'b00:   return {{24{sx & b[7]}}, b};
            2'b01:   return {{16{sx & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DW-1:0] store_data(input logic [DW-1:0] wd, input logic [1:0] sz);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // A misaligned slot0 cancels slot1 outright, so slot1 never raises its own exception then.
    always_comb begin
        mem_op = '0;
        mis    = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            mem_op[i] = in_slot_vld[i] & (in_load[i] | in_store[i]);
            mis[i]    = mem_op[i] & (((in_size[i] == 2'b01) & in_addr[i][0]) |
                                     (in_size[i][1] & (in_addr[i][1:0] != 2'b00)));
        end
        exc_in = {mis[1] & ~mis[0], mis[0]};
        go_in  = {mem_op[1] & ~mis[1] & ~mis[0], mem_op[0] & ~mis[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_valid) state_nx = go_in[0] ? REQ0 : (go_in[1] ? REQ1 : DONE);
            REQ0:  if (dmem_gnt) state_nx = st_q[0] ? (go_q[1] ? REQ1 : DONE) : WAIT0;
            WAIT0: if (dmem_rvalid) state_nx = go_q[1] ? REQ1 : DONE;
            REQ1:  if (dmem_gnt) state_nx = st_q[1] ? DONE : WAIT1;
            WAIT1: if (dmem_rvalid) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        sel        = (state == REQ1);
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        if (state == REQ0 || state == REQ1) begin
            dmem_req   = 1'b1;
            dmem_we    = st_q[sel];
            dmem_addr  = {addr_q[sel][AW-1:2], 2'b00};
            dmem_be    = store_be(addr_q[sel][1:0], size_q[sel]);
            dmem_wdata = store_data(wdata_q[sel], size_q[sel]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            st_q     <= '0;
            exc_q    <= '0;
            go_q     <= '0;
            sext_q   <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            wreg_q   <= '0;
            wb_valid <= '0;
            wb_exc   <= '0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= '0;
            wb_exc   <= '0;
            if (state == IDLE && in_valid) begin
                vld_q  <= {in_slot_vld[1] & ~mis[0], in_slot_vld[0]};
                st_q   <= in_store & ~in_load;
                exc_q  <= exc_in;
                go_q   <= go_in;
                sext_q <= in_sext;
                size_q <= in_size;
                addr_q <= in_addr;
                wdata_q <= in_wdata;
                data_q <= in_result;
                wreg_q <= in_wreg;
            end
            if (state == WAIT0 && dmem_rvalid)
                data_q[0] <= load_ext(dmem_rdata, addr_q[0][1:0], size_q[0], sext_q[0]);
            if (state == WAIT1 && dmem_rvalid)
                data_q[1] <= load_ext(dmem_rdata, addr_q[1][1:0], size_q[1], sext_q[1]);
            if (state == DONE) begin
                for (int unsigned i = 0; i < 2; i++)
                    wb_valid[i] <= vld_q[i] & ~exc_q[i] & ~st_q[i] & (wreg_q[i] != 5'd0);
                wb_exc  <= exc_q;
                wb_reg  <= wreg_q;
                wb_data <= data_q;
            end
        end
    end

endmodule
